// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and op decode helpers for the iterative divider
//
// Contents:
//   div_op_e    : RV32M divide op encoding (DIV, DIVU, REM, REMU)
//   div_state_e : divider FSM states (IDLE, RUN, FIX, DONE)
//   is_signed() : op treats operands as two's complement
//   wants_rem() : op returns the remainder rather than the quotient
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic is_signed(div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic wants_rem(div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring division step
//
// Ports:
//   rem_in  [W-1:0] : partial remainder entering the step (always < divisor)
//   divisor [W-1:0] : unsigned divisor magnitude
//   bit_in          : next dividend bit, MSB first
//   rem_out [W-1:0] : partial remainder leaving the step
//   q_bit           : quotient bit produced by this step
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] divisor,
    input  logic         bit_in,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // The shifted remainder needs W+1 bits; because rem_in < divisor the
    // difference always lies in (-divisor, divisor), so bit W is a true sign.
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[W];
    assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit with flush and fast path
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   flush_i             : abort any operation in flight, result discarded
//   start_i             : request, accepted in IDLE or DONE only
//   op_i [1:0]          : 0 DIV, 1 DIVU, 2 REM, 3 REMU
//   dividend_i, divisor_i [DATA_WIDTH-1:0] : operands, sampled with start_i
//   busy_o              : high during RUN and FIX
//   done_o              : one-cycle pulse, result_o valid in that cycle
//   result_o [DATA_WIDTH-1:0] : quotient or remainder, held until next accept
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int W    = DATA_WIDTH;
    localparam int R    = RADIX_BITS;
    localparam int ITER = W / R;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] ITER_C = CW'(ITER);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    div_state_e     state_q;
    div_op_e        op_q;
    logic [W-1:0]   dvd_q;    // dividend bits shift out the top, quotient bits shift in
    logic [W-1:0]   dvs_q;
    logic [W-1:0]   rem_q;
    logic           neg_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   result_q;
    logic           busy_q;
    logic           done_q;

    // ---------------- accept-time decode ----------------
    div_op_e        op_in;
    logic           in_signed;
    logic           dvd_neg;
    logic           dvs_neg;
    logic [W-1:0]   dvd_abs;
    logic [W-1:0]   dvs_abs;
    logic           div_zero;
    logic           ovf;
    logic           accept;
    logic [W-1:0]   fast_res;

    assign op_in     = div_op_e'(op_i);
    assign in_signed = is_signed(op_in);
    assign dvd_neg   = in_signed & dividend_i[W-1];
    assign dvs_neg   = in_signed & divisor_i[W-1];
    assign dvd_abs   = dvd_neg ? -dividend_i : dividend_i;
    assign dvs_abs   = dvs_neg ? -divisor_i  : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign ovf       = in_signed && (dividend_i == MOST_NEG) && (divisor_i == '1);
    assign accept    = start_i && !flush_i && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = wants_rem(op_in) ? dividend_i : '1;
        end else if (ovf) begin
            fast_res = wants_rem(op_in) ? '0 : dividend_i;
        end
    end

    // ---------------- restoring step chain ----------------
    logic [W-1:0] rem_chain [R+1];
    logic [R-1:0] q_bits;

    assign rem_chain[0] = rem_q;

    for (genvar i = 0; i < R; i++) begin : g_step
        div_step #(.W(W)) u_step (
            .rem_in  (rem_chain[i]),
            .divisor (dvs_q),
            .bit_in  (dvd_q[W-1-i]),
            .rem_out (rem_chain[i+1]),
            .q_bit   (q_bits[R-1-i])
        );
    end

    // ---------------- sign fixup ----------------
    logic [W-1:0] fix_sel;
    logic [W-1:0] fix_res;

    assign fix_sel = wants_rem(op_q) ? rem_q : dvd_q;
    assign fix_res = neg_q ? -fix_sel : fix_sel;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q <= op_in;
                        if (div_zero || ovf) begin
                            result_q <= fast_res;
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            dvd_q   <= dvd_abs;
                            dvs_q   <= dvs_abs;
                            rem_q   <= '0;
                            neg_q   <= wants_rem(op_in) ? dvd_neg : (dvd_neg ^ dvs_neg);
                            cnt_q   <= ITER_C;
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    rem_q <= rem_chain[R];
                    dvd_q <= {dvd_q[W-1-R:0], q_bits};
                    cnt_q <= cnt_q - ONE_C;
                    if (cnt_q == ONE_C) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    state_q  <= DONE;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
